// File: rtl/ra_stack.sv
// Return-address stack: fixed-depth circular LIFO feeding predicted return targets.
// Pushes past DEPTH overwrite the oldest entry; pops on empty raise a one-cycle flag.
module ra_stack #(
   parameter int N     = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [N-1:0]               push_data,
   output logic [N-1:0]               top,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [N-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_tos;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic          r_unf;

   logic          w_empty;
   logic          w_full;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [AW-1:0] w_tos_inc;
   logic [AW-1:0] w_tos_dec;
   logic [AW-1:0] w_tos_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_ovf_nxt;
   logic          w_unf_nxt;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL);
   assign w_tos_inc = r_tos + AW'(1);
   assign w_tos_dec = r_tos - AW'(1);

   always_comb begin
      w_we      = 1'b0;
      w_waddr   = r_tos;
      w_tos_nxt = r_tos;
      w_cnt_nxt = r_count;
      w_ovf_nxt = 1'b0;
      w_unf_nxt = 1'b0;
      if (flush) begin
         // Contents are kept; only the pointer and occupancy are dropped.
         w_tos_nxt = '0;
         w_cnt_nxt = '0;
      end else if (push && pop && !w_empty) begin
         w_we    = 1'b1;
         w_waddr = r_tos;
      end else if (push) begin
         // Also covers push+pop on empty, which behaves as a plain push.
         w_we      = 1'b1;
         w_waddr   = w_tos_inc;
         w_tos_nxt = w_tos_inc;
         if (w_full) w_ovf_nxt = 1'b1;
         else        w_cnt_nxt = r_count + CW'(1);
      end else if (pop) begin
         if (w_empty) begin
            w_unf_nxt = 1'b1;
         end else begin
            w_tos_nxt = w_tos_dec;
            w_cnt_nxt = r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_tos   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_we) r_mem[w_waddr] <= push_data;
         r_tos   <= w_tos_nxt;
         r_count <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
      end
   end

   assign top       = w_empty ? '0 : r_mem[r_tos];
   assign valid     = !w_empty;
   assign count     = r_count;
   assign overflow  = r_ovf;
   assign underflow = r_unf;

endmodule
